unidade_de_controle_mc: RTL and testbench
=========================================

UNIDADE_DE_CONTROLE_MC -- requirements
Module: unidade_de_controle_mc

Interface
REQ-001 SHALL have parameter ALUOP_W, default 4, ALU operation code width (minimum 4).
REQ-002 SHALL have parameter MEM_LAT, default 2, memory access length in cycles (minimum 1).
REQ-003 SHALL have ports: clk input 1, the only clock; rst input 1, synchronous active-high reset.
REQ-004 SHALL have inputs: opcode 7, f3 3, f7 7, instruction fields from the instruction register; in_valid 1, switch input ready; alu_done 1, multi-cycle ALU result ready.
REQ-005 SHALL have outputs: pc_write 1, PC update; ir_write 1, instruction register load; regWrite 1; ALUSrc 1; SeltipoSouB 1; MemToReg 1; MemWrite 1; MemRead 1; PCSrc 1; SwToReg 1; RegToDisp 1; HALT 1.
REQ-006 SHALL have outputs: ALUOp ALUOP_W bits; Tipo_Branch 3 bits; selSLT_JAL 2 bits; alu_start 1, multi-cycle ALU start pulse; estado 3 bits, current state.

Function
REQ-007 SHALL use states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, WAIT_IN=5, HALTED=6; code 7 SHALL go to FETCH.
REQ-008 FETCH: ir_write=1, pc_write=1 for one cycle, then DECODE.
REQ-009 DECODE: capture opcode/f3/f7 into internal registers; all later states SHALL decode only the captured copies.
REQ-010 Control outputs SHALL be combinational functions of the state and captured fields (Moore); every output not listed for a state is 0.
REQ-011 R-type (opcode 51): FETCH, DECODE, EXEC, WB, i.e. 4 cycles; regWrite=1 in WB only.
REQ-012 ALUOp SHALL be add 0000, sub 0001, and 0010, or 0011, sll 0100, srl 0101, xor 0110, xnor 1000, mul 1001, div 1010, zero-extended to ALUOP_W.
REQ-013 slt (f3=2): ALUOp=sub; selSLT_JAL=3 if f7=32, else 1.
REQ-014 lw (3, f3=2): EXEC with ALUSrc=1, then MEM with MemRead=1 for exactly MEM_LAT cycles (down-counter), then WB with MemToReg=1 and regWrite=1.
REQ-015 sw (35): EXEC with ALUSrc=1 and SeltipoSouB=1, then MEM with MemWrite=1 for MEM_LAT cycles, then FETCH.
REQ-016 addi (19): FETCH, DECODE, EXEC with ALUSrc=1, then WB.
REQ-017 Branch (99, f3 0/1/4/5/6 gives Tipo_Branch 1/2/3/4/5): EXEC with ALUOp=sub, PCSrc=1, pc_write=1, then FETCH; other f3 values SHALL be treated as NOP.
REQ-018 jal (111): EXEC with PCSrc=1, pc_write=1, Tipo_Branch=6, then WB with selSLT_JAL=2 and regWrite=1.
REQ-019 IN (55): DECODE to WAIT_IN; hold WAIT_IN while in_valid=0; in_valid=1 goes to WB with SwToReg=1 and regWrite=1.
REQ-020 OUT (23): EXEC with RegToDisp=1 for one cycle, then FETCH.
REQ-021 HALT (63): DECODE to HALTED; HALT=1 and all other controls 0; HALTED SHALL exit only on rst.
REQ-022 Unknown opcode: DECODE to FETCH (NOP); no write of any kind.
REQ-023 Tipo_Branch and selSLT_JAL SHALL be 0 outside the conditions in REQ-013/017/018.

Reset
REQ-024 rst=1 at a clock edge SHALL force estado=FETCH, clear the MEM counter and captured fields, and zero every output except the FETCH-state outputs, from any state including mid-MEM, WAIT_IN and HALTED.
REQ-025 The first FETCH cycle after rst deasserts SHALL assert ir_write and pc_write.

Configuration
REQ-026 Macro UNIDADE_MULDIV_EN defined: mul (f3=3, f7=0) and div (f3=3, f7=32) assert alu_start for the first EXEC cycle, hold EXEC until alu_done=1, then WB; alu_done=1 in the first EXEC cycle SHALL be honoured.
REQ-027 Macro undefined: f3=3 R-type SHALL execute as add (ALUOp 0000, 4 cycles); alu_start is tied to 0 and alu_done is ignored.

Verification
REQ-028 add (opcode 51, f3 0, f7 0) after reset -> estado 0,1,2,4,0; regWrite=1 only in cycle 4; ALUOp=0000.
REQ-029 lw with MEM_LAT=3 -> MemRead=1 for exactly 3 cycles, then WB with MemToReg=1; 7 cycles total.
REQ-030 IN with in_valid low for 5 cycles -> estado=5 for 5 cycles; cycle after in_valid=1: SwToReg=1, regWrite=1.
REQ-031 HALT, then 10 cycles of varied opcodes -> HALT=1 and estado=6 throughout; rst pulse -> estado=0.
REQ-032 With UNIDADE_MULDIV_EN, mul with alu_done after 4 cycles -> alu_start 1 cycle, ALUOp=1001 held, then WB; without the macro -> ALUOp=0000, 4 cycles.
REQ-033 rst asserted in the second MEM cycle of sw -> next cycle estado=0 and MemWrite=0.

Source files
------------

// File: rtl/unidade_de_controle_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : unidade_de_controle_mc_if
// Brief    : Instruction-field inputs and control outputs of the multicycle
//            control unit, with master (datapath/bench) and slave (FSM) views.
// Revision : 1.0 - initial release
// ============================================================================
interface unidade_de_controle_mc_if #(
   parameter int ALUOP_W = 4
) ();
   logic [6:0]         opcode;
   logic [2:0]         f3;
   logic [6:0]         f7;
   logic               in_valid;
   logic               alu_done;

   logic               pc_write;
   logic               ir_write;
   logic               regWrite;
   logic               ALUSrc;
   logic               SeltipoSouB;
   logic               MemToReg;
   logic               MemWrite;
   logic               MemRead;
   logic               PCSrc;
   logic               SwToReg;
   logic               RegToDisp;
   logic               HALT;
   logic [ALUOP_W-1:0] ALUOp;
   logic [2:0]         Tipo_Branch;
   logic [1:0]         selSLT_JAL;
   logic               alu_start;
   logic [2:0]         estado;

   modport slave (
      input  opcode, f3, f7, in_valid, alu_done,
      output pc_write, ir_write, regWrite, ALUSrc, SeltipoSouB, MemToReg,
             MemWrite, MemRead, PCSrc, SwToReg, RegToDisp, HALT, ALUOp,
             Tipo_Branch, selSLT_JAL, alu_start, estado
   );

   modport master (
      output opcode, f3, f7, in_valid, alu_done,
      input  pc_write, ir_write, regWrite, ALUSrc, SeltipoSouB, MemToReg,
             MemWrite, MemRead, PCSrc, SwToReg, RegToDisp, HALT, ALUOp,
             Tipo_Branch, selSLT_JAL, alu_start, estado
   );
endinterface
`default_nettype wire

// File: rtl/unidade_de_controle_mc.sv
`default_nettype none
// ============================================================================
// Module   : unidade_de_controle_mc
// Brief    : Moore multicycle control FSM (FETCH/DECODE/EXEC/MEM/WB/WAIT_IN/
//            HALTED). Optional multi-cycle mul/div: macro UNIDADE_MULDIV_EN.
// Revision : 1.0 - initial release
// ============================================================================
module unidade_de_controle_mc #(
   parameter int ALUOP_W = 4,
   parameter int MEM_LAT = 2
) (
   input  wire                        clk,
   input  wire                        rst,
   unidade_de_controle_mc_if.slave    bus
);
   localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

   localparam logic [6:0] c_OP_R    = 7'd51;
   localparam logic [6:0] c_OP_LW   = 7'd3;
   localparam logic [6:0] c_OP_SW   = 7'd35;
   localparam logic [6:0] c_OP_ADDI = 7'd19;
   localparam logic [6:0] c_OP_BR   = 7'd99;
   localparam logic [6:0] c_OP_JAL  = 7'd111;
   localparam logic [6:0] c_OP_IN   = 7'd55;
   localparam logic [6:0] c_OP_OUT  = 7'd23;
   localparam logic [6:0] c_OP_HALT = 7'd63;

   localparam logic [3:0] c_ALU_ADD  = 4'b0000;
   localparam logic [3:0] c_ALU_SUB  = 4'b0001;
   localparam logic [3:0] c_ALU_AND  = 4'b0010;
   localparam logic [3:0] c_ALU_OR   = 4'b0011;
   localparam logic [3:0] c_ALU_SLL  = 4'b0100;
   localparam logic [3:0] c_ALU_SRL  = 4'b0101;
   localparam logic [3:0] c_ALU_XOR  = 4'b0110;
   localparam logic [3:0] c_ALU_XNOR = 4'b1000;
   localparam logic [3:0] c_ALU_MUL  = 4'b1001;
   localparam logic [3:0] c_ALU_DIV  = 4'b1010;

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_EXEC    = 3'd2,
      S_MEM     = 3'd3,
      S_WB      = 3'd4,
      S_WAIT_IN = 3'd5,
      S_HALTED  = 3'd6
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [6:0]       opcode_q;
   logic [2:0]       f3_q;
   logic [6:0]       f7_q;

   logic             w_pc_write, w_ir_write, w_regWrite, w_ALUSrc;
   logic             w_SeltipoSouB, w_MemToReg, w_MemWrite, w_MemRead;
   logic             w_PCSrc, w_SwToReg, w_RegToDisp, w_HALT;
   logic [3:0]       w_aluop;
   logic [3:0]       w_r_aluop;
   logic [2:0]       w_tipo_branch;
   logic [2:0]       w_br_tipo;
   logic [1:0]       w_selSLT_JAL;
   logic [1:0]       w_slt_sel;
   logic             w_is_muldiv;
   logic             w_muldiv_wait;
   logic             w_alu_start;

   // Branch kind from f3; 0 means an unsupported branch, executed as a NOP.
   function automatic logic [2:0] br_tipo(input logic [2:0] f3);
      case (f3)
         3'd0:    br_tipo = 3'd1;
         3'd1:    br_tipo = 3'd2;
         3'd4:    br_tipo = 3'd3;
         3'd5:    br_tipo = 3'd4;
         3'd6:    br_tipo = 3'd5;
         default: br_tipo = 3'd0;
      endcase
   endfunction

   assign w_br_tipo = br_tipo(f3_q);
   assign w_slt_sel = (opcode_q == c_OP_R && f3_q == 3'd2)
                      ? ((f7_q == 7'd32) ? 2'd3 : 2'd1) : 2'd0;

`ifdef UNIDADE_MULDIV_EN
   logic busy_q;

   assign w_is_muldiv   = (opcode_q == c_OP_R) && (f3_q == 3'd3) &&
                          ((f7_q == 7'd0) || (f7_q == 7'd32));
   assign w_muldiv_wait = w_is_muldiv && !bus.alu_done;
   assign w_alu_start   = (state_q == S_EXEC) && w_is_muldiv && !busy_q;

   // busy_q marks EXEC cycles after the first, so alu_start is a single pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
      end else begin
         busy_q <= (state_q == S_EXEC) && w_muldiv_wait;
      end
   end
`else
   logic w_unused_alu_done;

   assign w_is_muldiv       = 1'b0;
   assign w_muldiv_wait     = 1'b0;
   assign w_alu_start       = 1'b0;
   assign w_unused_alu_done = bus.alu_done;
`endif

   always_comb begin
      w_r_aluop = c_ALU_ADD;
      case (f3_q)
         3'd0: w_r_aluop = (f7_q == 7'd32) ? c_ALU_SUB : c_ALU_ADD;
         3'd1: w_r_aluop = c_ALU_SLL;
         3'd2: w_r_aluop = c_ALU_SUB;
         3'd3: w_r_aluop = w_is_muldiv ? ((f7_q == 7'd32) ? c_ALU_DIV : c_ALU_MUL)
                                       : c_ALU_ADD;
         3'd4: w_r_aluop = (f7_q == 7'd32) ? c_ALU_XNOR : c_ALU_XOR;
         3'd5: w_r_aluop = c_ALU_SRL;
         3'd6: w_r_aluop = c_ALU_OR;
         3'd7: w_r_aluop = c_ALU_AND;
         default: w_r_aluop = c_ALU_ADD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_FETCH;
         cnt_q    <= '0;
         opcode_q <= '0;
         f3_q     <= '0;
         f7_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == S_DECODE) begin
            opcode_q <= bus.opcode;
            f3_q     <= bus.f3;
            f7_q     <= bus.f7;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      w_pc_write    = 1'b0;
      w_ir_write    = 1'b0;
      w_regWrite    = 1'b0;
      w_ALUSrc      = 1'b0;
      w_SeltipoSouB = 1'b0;
      w_MemToReg    = 1'b0;
      w_MemWrite    = 1'b0;
      w_MemRead     = 1'b0;
      w_PCSrc       = 1'b0;
      w_SwToReg     = 1'b0;
      w_RegToDisp   = 1'b0;
      w_HALT        = 1'b0;
      w_aluop       = c_ALU_ADD;
      w_tipo_branch = 3'd0;
      w_selSLT_JAL  = 2'd0;
      case (state_q)
         S_FETCH: begin
            w_ir_write = 1'b1;
            w_pc_write = 1'b1;
            state_d    = S_DECODE;
         end
         // Fields are still on the bus here; they are captured at this edge.
         S_DECODE: begin
            state_d = S_FETCH;
            case (bus.opcode)
               c_OP_R, c_OP_SW, c_OP_ADDI, c_OP_JAL, c_OP_OUT: state_d = S_EXEC;
               c_OP_LW:   if (bus.f3 == 3'd2) state_d = S_EXEC;
               c_OP_BR:   if (br_tipo(bus.f3) != 3'd0) state_d = S_EXEC;
               c_OP_IN:   state_d = S_WAIT_IN;
               c_OP_HALT: state_d = S_HALTED;
               default:   state_d = S_FETCH;
            endcase
         end
         S_EXEC: begin
            state_d = S_FETCH;
            case (opcode_q)
               c_OP_R: begin
                  w_aluop      = w_r_aluop;
                  w_selSLT_JAL = w_slt_sel;
                  state_d      = w_muldiv_wait ? S_EXEC : S_WB;
               end
               c_OP_LW: begin
                  w_ALUSrc = 1'b1;
                  state_d  = S_MEM;
                  cnt_d    = CNT_W'(MEM_LAT - 1);
               end
               c_OP_SW: begin
                  w_ALUSrc      = 1'b1;
                  w_SeltipoSouB = 1'b1;
                  state_d       = S_MEM;
                  cnt_d         = CNT_W'(MEM_LAT - 1);
               end
               c_OP_ADDI: begin
                  w_ALUSrc = 1'b1;
                  state_d  = S_WB;
               end
               c_OP_BR: begin
                  w_aluop       = c_ALU_SUB;
                  w_PCSrc       = 1'b1;
                  w_pc_write    = 1'b1;
                  w_tipo_branch = w_br_tipo;
               end
               c_OP_JAL: begin
                  w_PCSrc       = 1'b1;
                  w_pc_write    = 1'b1;
                  w_tipo_branch = 3'd6;
                  state_d       = S_WB;
               end
               c_OP_OUT: w_RegToDisp = 1'b1;
               default:  state_d = S_FETCH;
            endcase
         end
         S_MEM: begin
            w_MemRead  = (opcode_q == c_OP_LW);
            w_MemWrite = (opcode_q == c_OP_SW);
            if (cnt_q == '0) begin
               state_d = (opcode_q == c_OP_LW) ? S_WB : S_FETCH;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_WB: begin
            state_d = S_FETCH;
            case (opcode_q)
               c_OP_R: begin
                  w_regWrite   = 1'b1;
                  w_selSLT_JAL = w_slt_sel;
               end
               c_OP_LW: begin
                  w_regWrite = 1'b1;
                  w_MemToReg = 1'b1;
               end
               c_OP_ADDI: w_regWrite = 1'b1;
               c_OP_JAL: begin
                  w_regWrite   = 1'b1;
                  w_selSLT_JAL = 2'd2;
               end
               c_OP_IN: begin
                  w_regWrite = 1'b1;
                  w_SwToReg  = 1'b1;
               end
               default: w_regWrite = 1'b0;
            endcase
         end
         S_WAIT_IN: if (bus.in_valid) state_d = S_WB;
         S_HALTED: begin
            w_HALT  = 1'b1;
            state_d = S_HALTED;
         end
         default: state_d = S_FETCH;
      endcase
   end

   assign bus.pc_write    = w_pc_write;
   assign bus.ir_write    = w_ir_write;
   assign bus.regWrite    = w_regWrite;
   assign bus.ALUSrc      = w_ALUSrc;
   assign bus.SeltipoSouB = w_SeltipoSouB;
   assign bus.MemToReg    = w_MemToReg;
   assign bus.MemWrite    = w_MemWrite;
   assign bus.MemRead     = w_MemRead;
   assign bus.PCSrc       = w_PCSrc;
   assign bus.SwToReg     = w_SwToReg;
   assign bus.RegToDisp   = w_RegToDisp;
   assign bus.HALT        = w_HALT;
   assign bus.ALUOp       = ALUOP_W'(w_aluop);
   assign bus.Tipo_Branch = w_tipo_branch;
   assign bus.selSLT_JAL  = w_selSLT_JAL;
   assign bus.alu_start   = w_alu_start;
   assign bus.estado      = state_q;
endmodule
`default_nettype wire

// File: tb/tb_unidade_de_controle_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_unidade_de_controle_mc
// Brief    : Directed instruction sequences for the multicycle control FSM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unidade_de_controle_mc;
   localparam int ALUOP_W = 4;
   localparam int MEM_LAT = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   unidade_de_controle_mc_if #(.ALUOP_W(ALUOP_W)) bus ();

   unidade_de_controle_mc #(.ALUOP_W(ALUOP_W), .MEM_LAT(MEM_LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
      bus.opcode = op;
      bus.f3     = f3;
      bus.f7     = f7;
   endtask

   // Starts and ends at a FETCH sample point.
   task automatic run_r(input string tag, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [3:0] aluop, input logic [1:0] sel);
      set_instr(7'd51, f3, f7);
      check_eq({tag, "_fetch"}, bus.estado, 0);
      tick();
      check_eq({tag, "_decode"}, bus.estado, 1);
      tick();
      check_eq({tag, "_exec"}, bus.estado, 2);
      check_eq({tag, "_aluop"}, bus.ALUOp, aluop);
      check_eq({tag, "_exec_sel"}, bus.selSLT_JAL, sel);
      check_eq({tag, "_exec_rw"}, bus.regWrite, 0);
      check_eq({tag, "_alu_start"}, bus.alu_start, 0);
      tick();
      check_eq({tag, "_wb"}, bus.estado, 4);
      check_eq({tag, "_wb_rw"}, bus.regWrite, 1);
      check_eq({tag, "_wb_sel"}, bus.selSLT_JAL, sel);
      tick();
      check_eq({tag, "_done"}, bus.estado, 0);
   endtask

   task automatic run_br(input string tag, input logic [2:0] f3, input logic [2:0] tipo);
      set_instr(7'd99, f3, 7'd0);
      tick();
      check_eq({tag, "_decode"}, bus.estado, 1);
      tick();
      check_eq({tag, "_exec"}, bus.estado, 2);
      check_eq({tag, "_tipo"}, bus.Tipo_Branch, tipo);
      check_eq({tag, "_pcsrc"}, bus.PCSrc, 1);
      check_eq({tag, "_pcw"}, bus.pc_write, 1);
      check_eq({tag, "_aluop"}, bus.ALUOp, 1);
      tick();
      check_eq({tag, "_done"}, bus.estado, 0);
      check_eq({tag, "_tipo0"}, bus.Tipo_Branch, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lw_st[7]  = '{0, 1, 2, 3, 3, 3, 4};
      int lw_mr[7]  = '{0, 0, 0, 1, 1, 1, 0};
      int lw_mtr[7] = '{0, 0, 0, 0, 0, 0, 1};
      int lw_src[7] = '{0, 0, 1, 0, 0, 0, 0};
      int sw_st[6]  = '{0, 1, 2, 3, 3, 3};
      int sw_mw[6]  = '{0, 0, 0, 1, 1, 1};
      int sw_sel[6] = '{0, 0, 1, 0, 0, 0};
      logic [6:0] halt_ops[10] = '{7'd51, 7'd3, 7'd35, 7'd19, 7'd99,
                                   7'd111, 7'd55, 7'd23, 7'd0, 7'd63};

      set_instr(7'd0, 3'd0, 7'd0);
      bus.in_valid = 1'b0;
      bus.alu_done = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      check_eq("rst_estado", bus.estado, 0);
      check_eq("rst_ir_write", bus.ir_write, 1);
      check_eq("rst_pc_write", bus.pc_write, 1);
      check_eq("rst_regWrite", bus.regWrite, 0);
      check_eq("rst_HALT", bus.HALT, 0);
      check_eq("rst_ALUOp", bus.ALUOp, 0);
      rst = 1'b0;

      run_r("add",  3'd0, 7'd0,  4'b0000, 2'd0);
      run_r("sub",  3'd0, 7'd32, 4'b0001, 2'd0);
      run_r("slt32", 3'd2, 7'd32, 4'b0001, 2'd3);
      run_r("slt0", 3'd2, 7'd0,  4'b0001, 2'd1);
      run_r("sll",  3'd1, 7'd0,  4'b0100, 2'd0);
      run_r("xor",  3'd4, 7'd0,  4'b0110, 2'd0);
      run_r("or",   3'd6, 7'd0,  4'b0011, 2'd0);
      run_r("and",  3'd7, 7'd0,  4'b0010, 2'd0);

      set_instr(7'd3, 3'd2, 7'd0);
      for (int i = 0; i < 7; i++) begin
         check_eq("lw_estado", bus.estado, lw_st[i]);
         check_eq("lw_MemRead", bus.MemRead, lw_mr[i]);
         check_eq("lw_MemToReg", bus.MemToReg, lw_mtr[i]);
         check_eq("lw_regWrite", bus.regWrite, lw_mtr[i]);
         check_eq("lw_ALUSrc", bus.ALUSrc, lw_src[i]);
         tick();
      end
      check_eq("lw_end", bus.estado, 0);

      set_instr(7'd35, 3'd2, 7'd0);
      for (int i = 0; i < 6; i++) begin
         check_eq("sw_estado", bus.estado, sw_st[i]);
         check_eq("sw_MemWrite", bus.MemWrite, sw_mw[i]);
         check_eq("sw_SeltipoSouB", bus.SeltipoSouB, sw_sel[i]);
         tick();
      end
      check_eq("sw_end", bus.estado, 0);

      for (int i = 0; i < 4; i++) tick();
      check_eq("swrst_mem2", bus.estado, 3);
      check_eq("swrst_mw_before", bus.MemWrite, 1);
      rst = 1'b1;
      tick();
      check_eq("swrst_estado", bus.estado, 0);
      check_eq("swrst_MemWrite", bus.MemWrite, 0);
      check_eq("swrst_ir_write", bus.ir_write, 1);
      rst = 1'b0;

      run_br("beq",  3'd0, 3'd1);
      run_br("bge",  3'd5, 3'd4);
      run_br("bltu", 3'd6, 3'd5);

      set_instr(7'd99, 3'd2, 7'd0);
      tick();
      check_eq("brbad_pcw", bus.pc_write, 0);
      tick();
      check_eq("brbad_estado", bus.estado, 0);

      set_instr(7'd111, 3'd0, 7'd0);
      tick();
      tick();
      check_eq("jal_exec", bus.estado, 2);
      check_eq("jal_tipo", bus.Tipo_Branch, 6);
      check_eq("jal_pcsrc", bus.PCSrc, 1);
      check_eq("jal_pcw", bus.pc_write, 1);
      tick();
      check_eq("jal_wb", bus.estado, 4);
      check_eq("jal_sel", bus.selSLT_JAL, 2);
      check_eq("jal_rw", bus.regWrite, 1);
      check_eq("jal_wb_tipo", bus.Tipo_Branch, 0);
      tick();

      set_instr(7'd19, 3'd0, 7'd0);
      tick();
      tick();
      check_eq("addi_exec", bus.estado, 2);
      check_eq("addi_src", bus.ALUSrc, 1);
      tick();
      check_eq("addi_wb", bus.estado, 4);
      check_eq("addi_rw", bus.regWrite, 1);
      tick();

      set_instr(7'd23, 3'd0, 7'd0);
      tick();
      tick();
      check_eq("out_exec", bus.estado, 2);
      check_eq("out_disp", bus.RegToDisp, 1);
      tick();
      check_eq("out_done", bus.estado, 0);
      check_eq("out_disp0", bus.RegToDisp, 0);

      set_instr(7'd127, 3'd0, 7'd0);
      tick();
      check_eq("unk_decode", bus.estado, 1);
      check_eq("unk_rw", bus.regWrite, 0);
      tick();
      check_eq("unk_done", bus.estado, 0);

      set_instr(7'd55, 3'd0, 7'd0);
      tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("in_wait", bus.estado, 5);
         check_eq("in_wait_rw", bus.regWrite, 0);
      end
      bus.in_valid = 1'b1;
      tick();
      check_eq("in_wb", bus.estado, 4);
      check_eq("in_swtoreg", bus.SwToReg, 1);
      check_eq("in_rw", bus.regWrite, 1);
      bus.in_valid = 1'b0;
      tick();
      check_eq("in_done", bus.estado, 0);

`ifdef UNIDADE_MULDIV_EN
      set_instr(7'd51, 3'd3, 7'd0);
      tick();
      tick();
      check_eq("mul_exec1", bus.estado, 2);
      check_eq("mul_start1", bus.alu_start, 1);
      check_eq("mul_aluop1", bus.ALUOp, 9);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("mul_hold", bus.estado, 2);
         check_eq("mul_start0", bus.alu_start, 0);
         check_eq("mul_aluop", bus.ALUOp, 9);
      end
      bus.alu_done = 1'b1;
      tick();
      bus.alu_done = 1'b0;
      check_eq("mul_wb", bus.estado, 4);
      check_eq("mul_rw", bus.regWrite, 1);
      tick();

      set_instr(7'd51, 3'd3, 7'd32);
      tick();
      bus.alu_done = 1'b1;
      tick();
      check_eq("div_exec", bus.estado, 2);
      check_eq("div_start", bus.alu_start, 1);
      check_eq("div_aluop", bus.ALUOp, 10);
      tick();
      bus.alu_done = 1'b0;
      check_eq("div_wb", bus.estado, 4);
      tick();
`else
      bus.alu_done = 1'b0;
      run_r("mul_as_add", 3'd3, 7'd0, 4'b0000, 2'd0);
`endif

      set_instr(7'd63, 3'd0, 7'd0);
      tick();
      tick();
      check_eq("halt_estado", bus.estado, 6);
      check_eq("halt_HALT", bus.HALT, 1);
      for (int i = 0; i < 10; i++) begin
         set_instr(halt_ops[i], 3'(i), 7'd0);
         bus.in_valid = i[0];
         tick();
         check_eq("halt_hold", bus.estado, 6);
         check_eq("halt_HALT_hold", bus.HALT, 1);
         check_eq("halt_irw", bus.ir_write, 0);
      end
      bus.in_valid = 1'b0;
      rst = 1'b1;
      tick();
      check_eq("halt_rst_estado", bus.estado, 0);
      check_eq("halt_rst_HALT", bus.HALT, 0);
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
